// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : Bit-serial add/subtract sequencer, LSB first, one full-adder
//            evaluation per clock, with valid/ready on operands and result.
// Revision : 1.0
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_start_ready;
    logic             r_res_valid;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    assign w_fa_sum   = r_sa[0] ^ r_sb[0] ^ r_carry;
    assign w_fa_cout  = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
    assign w_last     = (r_cnt == C_LAST);
    assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sa          <= '0;
            r_sb          <= '0;
            r_sum_sh      <= '0;
            r_sum         <= '0;
            r_cnt         <= '0;
            r_carry       <= 1'b0;
            r_cout        <= 1'b0;
            r_ovf         <= 1'b0;
            r_start_ready <= 1'b1;
            r_res_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_sa          <= a;
                        r_sb          <= sub ? ~b : b;
                        r_carry       <= sub;
                        r_cnt         <= '0;
                        r_sum_sh      <= '0;
                        r_start_ready <= 1'b0;
                        r_state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= w_sum_next;
                    r_sa     <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb     <= {1'b0, r_sb[WIDTH-1:1]};
                    r_carry  <= w_fa_cout;
                    if (w_last) begin
                        // r_carry still holds the carry into the MSB here
                        r_sum       <= w_sum_next;
                        r_cout      <= w_fa_cout;
                        r_ovf       <= r_carry ^ w_fa_cout;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_res_valid   <= 1'b0;
                    r_start_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign start_ready = r_start_ready;
    assign res_valid   = r_res_valid;
    assign sum         = r_sum;
    assign cout        = r_cout;
    assign ovf         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Self-checking bench: vector table, random ops against an
//            arithmetic model, backpressure, mid-run reset, back-to-back, W=2.
// Revision : 1.0
// ============================================================================
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       sv8 = 1'b0, sr8, sub8 = 1'b0, rv8, rr8 = 1'b0, cout8, ovf8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       sv2 = 1'b0, sr2, sub2 = 1'b0, rv2, rr2 = 1'b0, cout2, ovf2;
    logic [1:0] a2 = '0, b2 = '0, sum2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .sub(sub8), .res_valid(rv8), .res_ready(rr8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
        .a(a2), .b(b2), .sub(sub2), .res_valid(rv2), .res_ready(rr2),
        .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        bit         tog;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: unsigned for sum/carry, signed range for overflow
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] sm, output logic c, output logic o);
        longint ua, ub, sa, sb, r, sr, lim;
        lim = longint'(1) << w;
        ua = longint'(a); ub = longint'(b);
        sa = (ua >= lim / 2) ? ua - lim : ua;
        sb = (ub >= lim / 2) ? ub - lim : ub;
        if (s) begin r = ua - ub; c = (ua >= ub); sr = sa - sb; end
        else   begin r = ua + ub; c = (r >= lim);  sr = sa + sb; end
        sm = 32'((r % lim + lim) % lim);
        o  = (sr >= lim / 2) || (sr < -(lim / 2));
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit tog);
        int w;
        int lat;
        w = 0;
        while (!sr8 && w < 30) begin tick(); w++; end
        chk("start_ready_before_accept", sr8, 1);
        a8 = a; b8 = b; sub8 = s; sv8 = 1'b1;
        tick();
        sv8 = 1'b0;
        chk("start_ready_low_in_run", sr8, 0);
        lat = 0;
        while (!rv8 && lat < 30) begin
            if (tog) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                sub8 = 1'($urandom_range(0, 1)); sv8 = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        sv8 = 1'b0;
        chk("latency8", lat, 8);
    endtask

    task automatic check8(input string tag, input logic [7:0] es, input logic ec, input logic eo);
        chk({tag, "_sum"}, sum8, es);
        chk({tag, "_cout"}, cout8, ec);
        chk({tag, "_ovf"}, ovf8, eo);
        chk({tag, "_excl"}, {rv8, sr8}, 2'b10);
    endtask

    task automatic consume8(input logic [7:0] es);
        rr8 = 1'b1;
        tick();
        rr8 = 1'b0;
        chk("post_consume_start_ready", sr8, 1);
        chk("post_consume_res_valid", rv8, 0);
        chk("post_consume_sum_held", sum8, es);
    endtask

    task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic s,
                        input logic [1:0] es, input logic ec, input logic eo);
        int lat;
        a2 = a; b2 = b; sub2 = s; sv2 = 1'b1;
        chk("w2_ready", sr2, 1);
        tick();
        sv2 = 1'b0;
        lat = 0;
        while (!rv2 && lat < 20) begin tick(); lat++; end
        chk("w2_latency", lat, 2);
        chk("w2_sum", sum2, es);
        chk("w2_cout", cout2, ec);
        chk("w2_ovf", ovf2, eo);
        rr2 = 1'b1;
        tick();
        rr2 = 1'b0;
        chk("w2_consume_ready", sr2, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

    initial begin
        vec_t        tbl[5];
        logic [31:0] ms;
        logic        mc, mo;
        logic [7:0]  ra, rb;
        logic        rs;
        int          acc[$];
        int          seen;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};

        repeat (3) tick();
        rst = 1'b0;
        chk("reset_start_ready", sr8, 1);
        chk("reset_res_valid", rv8, 0);
        chk("reset_sum", sum8, 0);
        chk("reset_cout_ovf", {cout8, ovf8}, 2'b00);
        chk("reset_w2_ready", sr2, 1);

        for (int i = 0; i < 5; i++) begin
            launch8(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].tog);
            check8("table", tbl[i].esum, tbl[i].ecout, tbl[i].eovf);
            consume8(tbl[i].esum);
        end

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 8'h33; rb = 8'h33; rs = 1'b1; end
            model(8, 32'(ra), 32'(rb), rs, ms, mc, mo);
            launch8(ra, rb, rs, i[0]);
            check8("random", ms[7:0], mc, mo);
            consume8(ms[7:0]);
        end

        launch8(8'h7F, 8'h01, 1'b0, 1'b0);
        check8("bp_first", 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check8("bp_hold", 8'h80, 1'b0, 1'b1);
        end
        consume8(8'h80);
        model(8, 32'h0C, 32'hF3, 1'b1, ms, mc, mo);
        launch8(8'h0C, 8'hF3, 1'b1, 1'b0);
        check8("bp_second", ms[7:0], mc, mo);
        consume8(ms[7:0]);

        a8 = 8'h0F; b8 = 8'h0F; sub8 = 1'b0; sv8 = 1'b1;
        tick();
        sv8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst_ready", sr8, 1);
        chk("midrun_rst_valid", rv8, 0);
        chk("midrun_rst_sum", sum8, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (rv8) seen++;
            tick();
        end
        chk("aborted_no_result", seen, 0);
        launch8(8'h01, 8'h01, 1'b0, 1'b0);
        check8("after_reset", 8'h02, 1'b0, 1'b0);
        consume8(8'h02);

        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; sv8 = 1'b1; rr8 = 1'b1;
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            if (sr8) acc.push_back(c);
            if (rv8) begin
                seen++;
                chk("b2b_sum", sum8, 8'h46);
            end
            tick();
        end
        sv8 = 1'b0;
        chk("b2b_accept_count_ge3", 32'(acc.size() >= 3), 1);
        for (int i = 1; i < acc.size(); i++) chk("b2b_interval", acc[i] - acc[i-1], 10);
        chk("b2b_results_seen_ge3", 32'(seen >= 3), 1);
        repeat (12) tick();
        rr8 = 1'b0;

        run2(2'b11, 2'b01, 1'b0, 2'b00, 1'b1, 1'b0);
        run2(2'b01, 2'b01, 1'b0, 2'b10, 1'b0, 1'b1);
        run2(2'b10, 2'b01, 1'b1, 2'b01, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
